link_framer: RTL and testbench
==============================

// Module: link_framer
// PURPOSE
//  Sits directly downstream of transportSend, on the channel toward transportRcv.
//  Buffers the transportSend byte stream (sending/packetOut) in a FIFO and wraps it into link frames.
//  Frame layout: SYNC, LEN, LEN payload bytes, CSUM.
//  Frames are emitted on a byte-wide valid/ready link with SOF/EOF markers.
//  Output sendData drives transportSend's sendData input as flow control.
// PARAMETERS
//  PAYLOAD_MAX   16      max payload bytes per frame (1..255)
//  FIFO_DEPTH    32      input FIFO entries, power of 2, >= PAYLOAD_MAX
//  IDLE_TIMEOUT  8       idle cycles (no push) before a short frame is closed
//  SYNC_BYTE     8'hA5   frame start marker
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset (0 = reset asserted)
//  sending    in   1   byte strobe from transportSend
//  packetIn   in   8   byte from transportSend, valid when sending=1
//  sendData   out  1   FIFO not full; fed back to transportSend sendData
//  txValid    out  1   txByte valid toward channel
//  txByte     out  8   framed output byte
//  txReady    in   1   channel accepts txByte this cycle
//  txSof      out  1   txByte is SYNC (first byte of frame)
//  txEof      out  1   txByte is CSUM (last byte of frame)
//  fifoCount  out  6   bytes currently buffered (0..FIFO_DEPTH)
//  overflow   out  1   sticky: a byte arrived while FIFO full
// BEHAVIOUR
//  Reset (async, reset=0):
//   - FSM to IDLE; FIFO emptied; idle counter cleared.
//   - txValid/txSof/txEof/overflow=0, txByte=0, fifoCount=0, sendData=1.
//   - Takes effect immediately, mid-frame included; the partial frame is abandoned, never resumed.
//  Push: sending=1 and count<FIFO_DEPTH writes packetIn at the clock edge.
//   - sending=1 while full: byte dropped, overflow<=1 (cleared only by reset).
//   - Simultaneous push and pop leaves count unchanged; a push while full is rejected even if a pop occurs in the same cycle.
//  sendData = (fifoCount != FIFO_DEPTH), combinational from registered count.
//  Idle counter: cleared on every accepted push; otherwise +1 per cycle; saturates at IDLE_TIMEOUT.
//  Handshake: a byte transfers on an edge with txValid&txReady.
//   - While txValid=1 and txReady=0, txByte/txSof/txEof hold stable.
//   - txValid never drops until the transfer.
//  FSM states: IDLE, SYNC, LEN, PAYLOAD, CSUM.
//   - IDLE -> SYNC when count>=PAYLOAD_MAX, or (count>0 and idleCnt==IDLE_TIMEOUT).
//     On that edge, latch len = min(count, PAYLOAD_MAX) and clear csum accumulator.
//     txValid rises the cycle after the edge on which the condition is seen.
//   - SYNC: txByte=SYNC_BYTE, txSof=1; on transfer -> LEN.
//   - LEN: txByte=len; acc<=len; on transfer -> PAYLOAD.
//   - PAYLOAD: txByte=FIFO head; each transfer pops FIFO, acc<=acc+byte (mod 256), remaining-1; after len-th transfer -> CSUM.
//   - CSUM: txByte=(~acc)+1 (8-bit), txEof=1; on transfer -> IDLE.
//  Arithmetic: LEN + payload + CSUM sums to 0 mod 256.
//  Ordering and frame boundaries:
//   - Bytes pushed during a frame stay queued and are never reordered.
//   - Next frame start is evaluated in IDLE only; min 1 idle cycle between frames.
//  FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is tracked separately for full/empty.
// TESTING
//  1. Push 0x01..0x10 back-to-back, txReady=1
//     -> A5,10,01..10,68; txSof on A5, txEof on 68; fifoCount ends 0.
//  2. Push 11,22,33 then idle
//     -> after 8 idle cycles, frame A5,03,11,22,33,97 is emitted.
//  3. Repeat test 1 with txReady toggling every cycle
//     -> bytes held stable while stalled; identical 19-byte sequence, no duplicates or losses.
//  4. txReady=0; push 33 bytes
//     -> sendData=0 after 32nd push; 33rd dropped; overflow=1; fifoCount=32.
//  5. Pull reset low mid-PAYLOAD
//     -> txValid=0 and fifoCount=0 immediately; after release, push 0x55 and idle -> A5,01,55,AA.
//  6. Push 20 bytes back-to-back
//     -> 16-byte frame, then a 4-byte frame after timeout; payload order preserved.

Source files
------------

// File: rtl/link_framer.sv
//------------------------------------------------------------------------------
// link_framer
//   Buffers the byte stream coming out of transportSend in a FIFO and wraps it
//   into link frames of the form SYNC, LEN, LEN payload bytes, CSUM. Frames go
//   out on a byte-wide valid/ready link with start/end-of-frame markers.
//   The checksum is chosen so that LEN + payload + CSUM == 0 (mod 256).
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous reset, active low (0 = in reset)
//   sending    in   1      byte strobe from transportSend
//   packetIn   in   8      byte from transportSend, valid when sending=1
//   sendData   out  1      FIFO not full; flow control back to transportSend
//   txValid    out  1      txByte is valid toward the channel
//   txByte     out  8      framed output byte
//   txReady    in   1      channel accepts txByte this cycle
//   txSof      out  1      txByte is the SYNC byte (first byte of a frame)
//   txEof      out  1      txByte is the CSUM byte (last byte of a frame)
//   fifoCount  out  CNT_W  bytes currently buffered (0..FIFO_DEPTH)
//   overflow   out  1      sticky: a byte arrived while the FIFO was full
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module link_framer #(
    parameter int         PAYLOAD_MAX  = 16,
    parameter int         FIFO_DEPTH   = 32,
    parameter int         IDLE_TIMEOUT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    localparam int        CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sending,
    input  logic [7:0]       packetIn,
    output logic             sendData,
    output logic             txValid,
    output logic [7:0]       txByte,
    input  logic             txReady,
    output logic             txSof,
    output logic             txEof,
    output logic [CNT_W-1:0] fifoCount,
    output logic             overflow
);

    localparam int               AW       = $clog2(FIFO_DEPTH);
    localparam int               IW       = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IW-1:0]    IDLE_MAX = IW'(IDLE_TIMEOUT);
    localparam logic [8:0]       PMAX9    = 9'(PAYLOAD_MAX);
    localparam logic [7:0]       PMAX8    = 8'(PAYLOAD_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [IW-1:0]    r_idleCnt;
    logic             r_overflow;
    logic [7:0]       r_len;
    logic [7:0]       r_remain;
    logic [7:0]       r_acc;
    logic             r_txValid;
    logic [7:0]       r_txByte;
    logic             r_txSof;
    logic             r_txEof;

    logic             w_push;
    logic             w_pop;
    logic             w_start;
    logic [7:0]       w_accNext;

    // A push while full is refused even if a pop happens on the same edge.
    assign w_push    = sending && (r_count != FULL_CNT);
    assign w_pop     = (r_state == ST_PAYLOAD) && r_txValid && txReady;
    assign w_start   = (r_state == ST_IDLE) &&
                       ((9'(r_count) >= PMAX9) ||
                        ((r_count != '0) && (r_idleCnt == IDLE_MAX)));
    assign w_accNext = r_acc + r_txByte;

    assign sendData  = (r_count != FULL_CNT);
    assign fifoCount = r_count;
    assign overflow  = r_overflow;
    assign txValid   = r_txValid;
    assign txByte    = r_txByte;
    assign txSof     = r_txSof;
    assign txEof     = r_txEof;

    // Storage needs no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= packetIn;
        end
    end

    // Pointers wrap naturally; the separate count disambiguates full/empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_idleCnt  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (sending && (r_count == FULL_CNT)) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_idleCnt <= '0;
            end else if (r_idleCnt != IDLE_MAX) begin
                r_idleCnt <= r_idleCnt + 1'b1;
            end
        end
    end

    // Outputs are registered and preloaded with the byte for the next state,
    // so they only change on a transfer and hold steady while stalled. The
    // payload byte after a pop is the entry behind the current head; it is
    // guaranteed present because len never exceeds the count latched at start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_remain  <= '0;
            r_acc     <= '0;
            r_txValid <= 1'b0;
            r_txByte  <= '0;
            r_txSof   <= 1'b0;
            r_txEof   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_SYNC;
                        r_len     <= (9'(r_count) >= PMAX9) ? PMAX8 : 8'(r_count);
                        r_acc     <= '0;
                        r_txValid <= 1'b1;
                        r_txByte  <= SYNC_BYTE;
                        r_txSof   <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (txReady) begin
                        r_state  <= ST_LEN;
                        r_txByte <= r_len;
                        r_txSof  <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (txReady) begin
                        r_state  <= ST_PAYLOAD;
                        r_acc    <= r_len;
                        r_remain <= r_len;
                        r_txByte <= r_mem[r_rdPtr];
                    end
                end
                ST_PAYLOAD: begin
                    if (txReady) begin
                        r_acc <= w_accNext;
                        if (r_remain == 8'd1) begin
                            r_state  <= ST_CSUM;
                            r_txByte <= (~w_accNext) + 8'd1;
                            r_txEof  <= 1'b1;
                        end else begin
                            r_remain <= r_remain - 8'd1;
                            r_txByte <= r_mem[r_rdPtr + 1'b1];
                        end
                    end
                end
                ST_CSUM: begin
                    if (txReady) begin
                        r_state   <= ST_IDLE;
                        r_txValid <= 1'b0;
                        r_txByte  <= '0;
                        r_txEof   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_framer.sv
//------------------------------------------------------------------------------
// tb_link_framer
//   Self-checking bench for link_framer. A reference model tracks the bytes the
//   FIFO accepted and the expected fill level, parses the transferred output
//   stream into frames, and builds expected frames from payload lists.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_link_framer;

    localparam int DEPTH = 32;

    typedef struct packed {
        logic [7:0] b;
        logic       sof;
        logic       eof;
    } xfer_t;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sending = 1'b0;
    logic [7:0] packetIn = 8'h00;
    logic       txReady = 1'b0;
    logic       sendData;
    logic       txValid;
    logic [7:0] txByte;
    logic       txSof;
    logic       txEof;
    logic [5:0] fifoCount;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         mdlCount = 0;
    logic       mdlOverflow = 1'b0;
    int         pstate = 0;
    int         premain = 0;
    bq_t        acceptedLog;
    xfer_t      cap[$];
    xfer_t      expQ[$];
    int         stallErr = 0;
    int         cntErr = 0;
    int         gapErr = 0;
    logic       prevStalled = 1'b0;
    logic [7:0] prevByte = 8'h00;
    logic       prevSof = 1'b0;
    logic       prevEof = 1'b0;
    logic       gapPending = 1'b0;
    logic       rdyT = 1'b0;

    link_framer dut (
        .clk      (clk),
        .reset    (reset),
        .sending  (sending),
        .packetIn (packetIn),
        .sendData (sendData),
        .txValid  (txValid),
        .txByte   (txByte),
        .txReady  (txReady),
        .txSof    (txSof),
        .txEof    (txEof),
        .fifoCount(fifoCount),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearModel();
        mdlCount    = 0;
        mdlOverflow = 1'b0;
        pstate      = 0;
        premain     = 0;
        prevStalled = 1'b0;
        gapPending  = 1'b0;
        acceptedLog.delete();
        cap.delete();
        expQ.delete();
    endtask

    // Appends one expected frame built from the framing rules.
    task automatic addFrame(input bq_t pl);
        xfer_t x;
        int    s;
        s = pl.size();
        x.b = 8'hA5; x.sof = 1'b1; x.eof = 1'b0; expQ.push_back(x);
        x.b = 8'(pl.size()); x.sof = 1'b0; expQ.push_back(x);
        foreach (pl[k]) begin
            x.b = pl[k];
            expQ.push_back(x);
            s += int'(pl[k]);
        end
        x.b = 8'((256 - (s % 256)) % 256); x.eof = 1'b1; expQ.push_back(x);
    endtask

    // One clock cycle: sample outputs at the falling edge, update the model,
    // then drive the inputs for the next rising edge.
    task automatic cycle(input logic doPush, input logic [7:0] data, input logic ready);
        logic  accepted;
        logic  popNow;
        xfer_t x;
        @(negedge clk);
        if (prevStalled && (txValid !== 1'b1 || txByte !== prevByte ||
                            txSof !== prevSof || txEof !== prevEof)) stallErr++;
        if (gapPending && txValid !== 1'b0) gapErr++;
        gapPending = 1'b0;
        if (fifoCount !== 6'(mdlCount) || sendData !== (mdlCount != DEPTH)) cntErr++;
        if (overflow !== mdlOverflow) cntErr++;
        sending  = doPush;
        packetIn = data;
        txReady  = ready;
        popNow   = 1'b0;
        if (txValid === 1'b1 && ready) begin
            x.b = txByte; x.sof = txSof; x.eof = txEof;
            cap.push_back(x);
            case (pstate)
                0: pstate = 1;
                1: begin
                    premain = int'(txByte);
                    pstate  = (premain == 0) ? 3 : 2;
                end
                2: begin
                    popNow = 1'b1;
                    premain--;
                    if (premain == 0) pstate = 3;
                end
                default: begin
                    pstate     = 0;
                    gapPending = 1'b1;
                end
            endcase
        end
        prevStalled = (txValid === 1'b1) && !ready;
        prevByte    = txByte;
        prevSof     = txSof;
        prevEof     = txEof;
        accepted    = doPush && (mdlCount < DEPTH);
        if (doPush && !accepted) mdlOverflow = 1'b1;
        if (accepted) acceptedLog.push_back(data);
        mdlCount = mdlCount + int'(accepted) - int'(popNow);
    endtask

    task automatic runIdle(input int nBytes, input logic toggle, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cap.size() >= nBytes && pstate == 0 && mdlCount == 0) begin
                ok = 1'b1;
                break;
            end
            cycle(1'b0, 8'h00, toggle ? rdyT : 1'b1);
            rdyT = ~rdyT;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; sending = 1'b0; txReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_txValid: got %b want 0", txValid); end
        checks++;
        if ({txSof, txEof, overflow} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {txSof, txEof, overflow}); end
        checks++;
        if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_txByte: got %h want 00", txByte); end
        checks++;
        if (fifoCount !== 6'd0 || sendData !== 1'b1) begin errors++; $display("[TB] FAIL reset_fifo: count %0d sendData %b want 0/1", fifoCount, sendData); end
        @(negedge clk);
        reset = 1'b1;
        clearModel();
        repeat (12) cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (txValid !== 1'b0 || cap.size() != 0) begin errors++; $display("[TB] FAIL reset_empty_idle: txValid %b bytes %0d want 0/0", txValid, cap.size()); end
    endtask

    task automatic test_full_frame();
        bq_t  pl;
        logic ok;
        clearModel();
        for (int i = 1; i <= 16; i++) begin
            pl.push_back(8'(i));
            cycle(1'b1, 8'(i), 1'b1);
        end
        addFrame(pl);
        runIdle(19, 1'b0, 100, ok);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL full_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL full_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
        checks++;
        if (fifoCount !== 6'd0) begin errors++; $display("[TB] FAIL full_count_end: got %0d want 0", fifoCount); end
    endtask

    task automatic test_timeout();
        bq_t  pl;
        logic ok;
        int   firstValid;
        clearModel();
        pl = '{8'h11, 8'h22, 8'h33};
        foreach (pl[k]) cycle(1'b1, pl[k], 1'b1);
        addFrame(pl);
        firstValid = -1;
        for (int j = 1; j <= 20 && firstValid < 0; j++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (txValid === 1'b1) firstValid = j;
        end
        checks++;
        if (firstValid != 10) begin errors++; $display("[TB] FAIL timeout_start: txValid first seen at idle sample %0d want 10", firstValid); end
        runIdle(6, 1'b0, 40, ok);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL timeout_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL timeout_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
    endtask

    task automatic test_stall();
        bq_t  pl;
        logic ok;
        clearModel();
        stallErr = 0;
        for (int i = 1; i <= 16; i++) begin
            pl.push_back(8'(i));
            cycle(1'b1, 8'(i), rdyT);
            rdyT = ~rdyT;
        end
        addFrame(pl);
        runIdle(19, 1'b1, 150, ok);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL stall_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL stall_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
        checks++;
        if (stallErr != 0) begin errors++; $display("[TB] FAIL stall_hold: %0d stalled cycles changed output, want 0", stallErr); end
    endtask

    task automatic test_overflow();
        bq_t        pl;
        logic       ok;
        logic [7:0] d;
        clearModel();
        for (int i = 0; i < 33; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 32) pl.push_back(d);
            cycle(1'b1, d, 1'b0);
        end
        checks++;
        if (sendData !== 1'b0 || fifoCount !== 6'd32) begin errors++; $display("[TB] FAIL ovf_full: sendData %b count %0d want 0/32", sendData, fifoCount); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b want 0", overflow); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== 1'b1 || fifoCount !== 6'd32) begin errors++; $display("[TB] FAIL ovf_drop: overflow %b count %0d want 1/32", overflow, fifoCount); end
        addFrame(pl[0:15]);
        addFrame(pl[16:31]);
        runIdle(38, 1'b0, 150, ok);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL ovf_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL ovf_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        bq_t  pl;
        logic ok;
        clearModel();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 60 && !(pstate == 2 && premain <= 12); i++) cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (pstate != 2) begin errors++; $display("[TB] FAIL rmid_reach: frame parser state %0d want 2 (payload)", pstate); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (txValid !== 1'b0 || fifoCount !== 6'd0) begin errors++; $display("[TB] FAIL rmid_async: txValid %b count %0d want 0/0", txValid, fifoCount); end
        checks++;
        if (overflow !== 1'b0 || sendData !== 1'b1 || txSof !== 1'b0 || txEof !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_flags: ovf %b sendData %b sof %b eof %b want 0 1 0 0", overflow, sendData, txSof, txEof);
        end
        sending = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clearModel();
        pl = '{8'h55};
        cycle(1'b1, 8'h55, 1'b1);
        addFrame(pl);
        runIdle(4, 1'b0, 40, ok);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL rmid_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL rmid_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t        pl;
        logic       ok;
        logic [7:0] d;
        clearModel();
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            pl.push_back(d);
            cycle(1'b1, d, 1'b1);
        end
        addFrame(pl[0:15]);
        addFrame(pl[16:19]);
        runIdle(26, 1'b0, 120, ok);
        checks++;
        if (!ok || cap.size() != expQ.size()) begin errors++; $display("[TB] FAIL b2b_len: got %0d bytes want %0d", cap.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d: got %h sof%b eof%b want %h sof%b eof%b",
                         i, cap[i].b, cap[i].sof, cap[i].eof, expQ[i].b, expQ[i].sof, expQ[i].eof);
            end
        end
    endtask

    task automatic test_random();
        logic ok;
        int   idx;
        int   logIdx;
        int   len;
        int   s;
        clearModel();
        cntErr = 0; stallErr = 0; gapErr = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 75));
        end
        runIdle(1, 1'b0, 800, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rand_drain: fifo model %0d parser %0d want 0/0", mdlCount, pstate); end
        idx = 0;
        logIdx = 0;
        while (idx < cap.size()) begin
            checks++;
            if (cap[idx].b !== 8'hA5 || cap[idx].sof !== 1'b1 || cap[idx].eof !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_sync@%0d: got %h sof%b eof%b want a5 sof1 eof0", idx, cap[idx].b, cap[idx].sof, cap[idx].eof);
                break;
            end
            if (idx + 1 >= cap.size()) break;
            len = int'(cap[idx + 1].b);
            checks++;
            if (len < 1 || len > 16 || idx + 2 + len >= cap.size()) begin
                errors++;
                $display("[TB] FAIL rand_lenfield@%0d: got %0d want 1..16 within stream", idx, len);
                break;
            end
            s = len;
            for (int k = 0; k < len; k++) begin
                checks++;
                if (logIdx >= acceptedLog.size() || cap[idx + 2 + k].b !== acceptedLog[logIdx] ||
                    cap[idx + 2 + k].sof !== 1'b0 || cap[idx + 2 + k].eof !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_payload%0d: got %h want %h", logIdx, cap[idx + 2 + k].b,
                             (logIdx < acceptedLog.size()) ? acceptedLog[logIdx] : 8'hxx);
                end
                s += int'(cap[idx + 2 + k].b);
                logIdx++;
            end
            checks++;
            if (cap[idx + 2 + len].eof !== 1'b1 || ((s + int'(cap[idx + 2 + len].b)) % 256) != 0) begin
                errors++;
                $display("[TB] FAIL rand_csum@%0d: got %h eof%b want %h eof1", idx, cap[idx + 2 + len].b,
                         cap[idx + 2 + len].eof, 8'((256 - (s % 256)) % 256));
            end
            idx += len + 3;
        end
        checks++;
        if (logIdx != acceptedLog.size()) begin errors++; $display("[TB] FAIL rand_total: framed %0d bytes want %0d", logIdx, acceptedLog.size()); end
        checks++;
        if (cntErr != 0) begin errors++; $display("[TB] FAIL rand_count: %0d cycles with wrong fifoCount/sendData/overflow, want 0", cntErr); end
        checks++;
        if (stallErr != 0 || gapErr != 0) begin errors++; $display("[TB] FAIL rand_protocol: stall changes %0d, missing gaps %0d, want 0/0", stallErr, gapErr); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_timeout();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
